legv8_uart_tx: RTL and testbench

//  UART transmitter directly downstream of the LEGv8 multicycle controller.

---
 rtl/legv8_uart_tx.sv | 173 +++++++++++++++++
 tb/tb_legv8_uart_tx.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/legv8_uart_tx.sv
// legv8_uart_tx -- 8N1 UART transmitter fed by the LEGv8 multicycle
// controller's result-send sequence. One byte per tx_start request,
// LSB first, with tx_active serving as the controller's busy/ack signal.
//
// Optional build macro: UART_TX_PARITY_EN
//   defined   -> a parity bit (^data ^ PARITY_ODD) is inserted before the
//                stop bit, giving an 11-bit frame.
//   undefined -> plain 8N1, no parity state or register.
//
// Handshake: a request is accepted on any rising edge where the FSM is in
// IDLE and tx_start=1. The accepting edge latches tx_data and raises
// tx_active. tx_active then stays high for the whole frame, and any
// tx_start seen during that time is dropped. tx_done pulses for exactly
// one cycle on the edge where tx_active falls. The two are never high
// together.
//
// dbg_state exposes the FSM encoding so it can be observed from outside.

module legv8_uart_tx #(
  parameter int CLK_FREQ_HZ = 50_000_000,
  parameter int BAUD_RATE   = 115_200,
  parameter int PARITY_ODD  = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  output logic       tx_active,
  output logic       tx_done,
  output logic       tx_serial,
  output logic [2:0] dbg_state
);

  localparam int CLKS_PER_BIT = CLK_FREQ_HZ / BAUD_RATE;
  localparam int CW           = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST_CLK = CW'(CLKS_PER_BIT - 1);

  // Parameter sanity checks at elaboration time.
  generate
    if (CLKS_PER_BIT < 2) begin : g_bad_rate
      $error("legv8_uart_tx: CLKS_PER_BIT must be >= 2");
    end
    if ((PARITY_ODD != 0) && (PARITY_ODD != 1)) begin : g_bad_parity
      $error("legv8_uart_tx: PARITY_ODD must be 0 or 1");
    end
  endgenerate

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    START_BIT  = 3'd1,
    DATA_BITS  = 3'd2,
    STOP_BIT   = 3'd3
`ifdef UART_TX_PARITY_EN
    ,
    PARITY_BIT = 3'd4
`endif
  } state_t;

  state_t        state;
  logic [CW-1:0] clk_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shift_reg;
`ifdef UART_TX_PARITY_EN
  // The original byte is kept apart from the shift register, which is
  // consumed as the data bits go out.
  logic [7:0]    data_latched;
`endif

  assign dbg_state = state;

  // Single FSM: bit timing, shifting and all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      clk_cnt      <= '0;
      bit_idx      <= 3'd0;
      shift_reg    <= 8'h00;
      tx_serial    <= 1'b1;
      tx_active    <= 1'b0;
      tx_done      <= 1'b0;
`ifdef UART_TX_PARITY_EN
      data_latched <= 8'h00;
`endif
    end else begin
      // tx_done is a single-cycle pulse; only the end of the stop bit sets it.
      tx_done <= 1'b0;
      case (state)
        IDLE: begin
          tx_serial <= 1'b1;
          tx_active <= 1'b0;
          if (tx_start) begin
            shift_reg    <= tx_data;
`ifdef UART_TX_PARITY_EN
            data_latched <= tx_data;
`endif
            tx_serial    <= 1'b0;
            tx_active    <= 1'b1;
            clk_cnt      <= '0;
            bit_idx      <= 3'd0;
            state        <= START_BIT;
          end
        end

        START_BIT: begin
          if (clk_cnt == LAST_CLK) begin
            clk_cnt   <= '0;
            tx_serial <= shift_reg[0];
            shift_reg <= {1'b0, shift_reg[7:1]};
            bit_idx   <= 3'd0;
            state     <= DATA_BITS;
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end

        DATA_BITS: begin
          if (clk_cnt == LAST_CLK) begin
            clk_cnt <= '0;
            if (bit_idx == 3'd7) begin
              bit_idx <= 3'd0;
`ifdef UART_TX_PARITY_EN
              tx_serial <= (^data_latched) ^ (PARITY_ODD != 0);
              state     <= PARITY_BIT;
`else
              tx_serial <= 1'b1;
              state     <= STOP_BIT;
`endif
            end else begin
              tx_serial <= shift_reg[0];
              shift_reg <= {1'b0, shift_reg[7:1]};
              bit_idx   <= bit_idx + 3'd1;
            end
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end

`ifdef UART_TX_PARITY_EN
        PARITY_BIT: begin
          if (clk_cnt == LAST_CLK) begin
            clk_cnt   <= '0;
            tx_serial <= 1'b1;
            state     <= STOP_BIT;
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
`endif

        STOP_BIT: begin
          if (clk_cnt == LAST_CLK) begin
            clk_cnt   <= '0;
            tx_serial <= 1'b1;
            tx_active <= 1'b0;
            tx_done   <= 1'b1;
            state     <= IDLE;
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end

        default: begin
          clk_cnt   <= '0;
          bit_idx   <= 3'd0;
          tx_serial <= 1'b1;
          tx_active <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_legv8_uart_tx.sv
// tb_legv8_uart_tx -- directed bench for legv8_uart_tx at CLKS_PER_BIT=4.
// Outputs are sampled on the falling edge; inputs change on the falling edge.
// Build with +define+UART_TX_PARITY_EN to exercise the parity frame.

module tb_legv8_uart_tx;

  localparam int CPB      = 4;
  localparam int PAR_ODD  = 0;
`ifdef UART_TX_PARITY_EN
  localparam int FLEN     = 11;
`else
  localparam int FLEN     = 10;
`endif

  logic       clk;
  logic       rst_n;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       tx_active;
  logic       tx_done;
  logic       tx_serial;
  logic [2:0] dbg_state;

  int passed;
  int total;
  int done_cnt;

  logic [7:0] exp_q[$];

  legv8_uart_tx #(
    .CLK_FREQ_HZ (16),
    .BAUD_RATE   (4),
    .PARITY_ODD  (PAR_ODD)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .tx_start  (tx_start),
    .tx_data   (tx_data),
    .tx_active (tx_active),
    .tx_done   (tx_done),
    .tx_serial (tx_serial),
    .dbg_state (dbg_state)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, required finish before 200000 ns");
    $fatal(1);
  end

  // Count tx_done pulses independently of the frame checks.
  always @(posedge clk) begin
    if (tx_done) done_cnt <= done_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
  endtask

  // Expected frame, bit 0 first on the line.
  function automatic logic [10:0] frame_of(input logic [7:0] d);
`ifdef UART_TX_PARITY_EN
    return {1'b1, (^d) ^ (PAR_ODD != 0), d, 1'b0};
`else
    return {1'b0, 1'b1, d, 1'b0};
`endif
  endfunction

  task automatic idle_check(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check({tag, "_serial"}, tx_serial, 1'b1);
      check({tag, "_active"}, tx_active, 1'b0);
    end
  endtask

  task automatic wait_idle();
    int i;
    i = 0;
    while (tx_active && i < 200) begin
      @(negedge clk);
      i++;
    end
    check("wait_idle", tx_active, 1'b0);
  endtask

  // Request one byte, holding tx_start for 'hold' extra cycles, and check
  // every cycle of the frame against fr. A mid-bit receiver decodes the data
  // bits and the result is scored against exp_q.
  task automatic run_frame(input logic [7:0] d, input int hold, input logic [10:0] fr);
    logic [7:0] rx;
    logic [7:0] want;
    int b;
    exp_q.push_back(d);
    rx = 8'h00;
    @(negedge clk);
    tx_start = 1'b1;
    tx_data  = d;
    @(negedge clk);
    for (int k = 0; k < FLEN * CPB; k++) begin
      b = k / CPB;
      check($sformatf("serial_k%0d", k), tx_serial, fr[b]);
      check($sformatf("active_k%0d", k), tx_active, 1'b1);
      check($sformatf("done_k%0d", k), tx_done, 1'b0);
      if ((k % CPB) == CPB / 2 && b >= 1 && b <= 8) rx[b-1] = tx_serial;
      if (k == hold) tx_start = 1'b0;
      if (k == 5) tx_data = ~d;
      @(negedge clk);
    end
    check("end_active", tx_active, 1'b0);
    check("end_done", tx_done, 1'b1);
    check("end_serial", tx_serial, 1'b1);
    want = exp_q.pop_front();
    check("rx_byte", rx, want);
    @(negedge clk);
    check("post_done", tx_done, 1'b0);
    check("post_active", tx_active, 1'b0);
    check("post_serial", tx_serial, 1'b1);
  endtask

  initial begin
    int base;
    passed   = 0;
    total    = 0;
    done_cnt = 0;
    rst_n    = 1'b0;
    tx_start = 1'b0;
    tx_data  = 8'h00;

    // 1. Reset state and idle line
    repeat (3) @(negedge clk);
    check("rst_serial", tx_serial, 1'b1);
    check("rst_active", tx_active, 1'b0);
    check("rst_done", tx_done, 1'b0);
    check("rst_state", dbg_state, 3'd0);
    rst_n = 1'b1;
    idle_check("idle20", 20);

    // 2. Single-cycle request, 0xA5
`ifdef UART_TX_PARITY_EN
    run_frame(8'hA5, 0, {1'b1, 1'b0, 8'hA5, 1'b0});
`else
    run_frame(8'hA5, 0, {1'b0, 1'b1, 8'hA5, 1'b0});
`endif
    idle_check("idle_a5", 3);

    // 3. Controller handshake: tx_start held one cycle past tx_active
    run_frame(8'h3C, 1, frame_of(8'h3C));
    idle_check("no_second", 12);

    // 4. Four bytes of 0x78563412, waiting for !tx_active each time
    base = done_cnt;
    wait_idle();
    run_frame(8'h12, 1, frame_of(8'h12));
    wait_idle();
    run_frame(8'h34, 1, frame_of(8'h34));
    wait_idle();
    run_frame(8'h56, 1, frame_of(8'h56));
    wait_idle();
    run_frame(8'h78, 1, frame_of(8'h78));
    check("done_pulses", done_cnt - base, 4);
    check("queue_empty", exp_q.size(), 0);

    // 5. Asynchronous reset during data bit 3 of 0xFF
    @(negedge clk);
    tx_start = 1'b1;
    tx_data  = 8'hFF;
    @(negedge clk);
    tx_start = 1'b0;
    repeat (17) @(negedge clk);
    check("mid_active", tx_active, 1'b1);
    check("mid_state", dbg_state, 3'd2);
    rst_n = 1'b0;
    #1;
    check("arst_serial", tx_serial, 1'b1);
    check("arst_active", tx_active, 1'b0);
    check("arst_state", dbg_state, 3'd0);
    @(negedge clk);
    rst_n = 1'b1;
    idle_check("after_rst", 8);
    run_frame(8'h00, 0, frame_of(8'h00));

`ifdef UART_TX_PARITY_EN
    // 6. Odd population gives parity bit 1 with even parity
    run_frame(8'h07, 0, {1'b1, 1'b1, 8'h07, 1'b0});
`endif

    idle_check("final", 4);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
